serial_adder: RTL and testbench

Bit-serial N-bit adder, the sequential stage built around the team's `half_adder` cell. Two half-adder instances plus an OR form a full-adder bit cell. A carry flip-flop and operand shift registers add two WIDTH-bit operands LSB-first, one bit per clock. The block accepts an operation on a `start` pulse, reports progress on `busy`, and publishes a stable sum and carry-out with a one-cycle `done` pulse. It is the first multi-cycle arithmetic block in the tutorial chain and trades WIDTH+2 cycles per add for a single adder cell.

---
 rtl/serial_adder_if.sv | 23 ++
 rtl/serial_adder.sv | 102 ++++++++++
 tb/tb_serial_adder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// master drives the request side, and slave is the adder itself.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell (two half adders plus an OR),
// a carry flop and operand shift registers. It adds LSB-first, one bit per clock.
// A start pulse in idle launches an add. The sum and c_out outputs then update once,
// on the last bit, with a one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] ra_q, rb_q, rs_q, sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, c_out_q, busy_q, done_q;

  logic             ha0_s, ha0_c, ha1_s, ha1_c;
  logic             carry_d;
  logic [WIDTH-1:0] ra_shift, rb_shift, rs_shift;

  // Full-adder bit cell built from two half adders; also forms the shifted words.
  always_comb begin
    ha0_s    = ra_q[0] ^ rb_q[0];
    ha0_c    = ra_q[0] & rb_q[0];
    ha1_s    = ha0_s ^ carry_q;
    ha1_c    = ha0_s & carry_q;
    carry_d  = ha0_c | ha1_c;
    ra_shift = ra_q >> 1;
    rb_shift = rb_q >> 1;
    rs_shift = rs_q >> 1;
    // New sum bit enters at the MSB, so after WIDTH steps rs holds the full sum.
    rs_shift[WIDTH-1] = ha1_s;
  end

  // Control FSM plus datapath registers. All outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StBusy;
            ra_q    <= bus.a;
            rb_q    <= bus.b;
            rs_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StBusy: begin
          ra_q    <= ra_shift;
          rb_q    <= rb_shift;
          rs_q    <= rs_shift;
          carry_q <= carry_d;
          if (cnt_q == CntLast) begin
            // Publish the result including the bit processed on this edge.
            // The counter holds here instead of wrapping.
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= rs_shift;
            c_out_q <= carry_d;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a vector table run through a timing-checking
// add task, plus hand sequences for start-while-busy, back-to-back, mid-op reset, WIDTH=1.
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_failed = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One add: pulse start and then watch W+3 cycles.
  // inj_k >= 0 re-pulses start with 0xAA/0x55 at that sample, and that start must be ignored.
  task automatic do_add(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] es, input logic ec, input int inj_k);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_k = -1;
    int overlap = 0;
    logic [W-1:0] sum_at_done = '0;
    bus8.start = 1'b1;
    bus8.a     = va;
    bus8.b     = vb;
    step();  // E0 accepted
    bus8.start = 1'b0;
    bus8.a     = ~va;
    bus8.b     = ~vb;
    for (int k = 0; k <= W + 3; k++) begin
      if (bus8.busy) busy_cnt++;
      if (bus8.done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          sum_at_done = bus8.sum;
        end
      end
      if (bus8.busy && bus8.done) overlap++;
      if (k == inj_k) begin
        bus8.start = 1'b1;
        bus8.a     = 8'hAA;
        bus8.b     = 8'h55;
      end else begin
        bus8.start = 1'b0;
      end
      if (k < W + 3) step();
    end
    check("busy_cycles", busy_cnt, W);
    check("done_edge", done_k, W);
    check("done_count", done_cnt, 1);
    check("busy_done_overlap", overlap, 0);
    check("sum_at_done", sum_at_done, es);
    check("sum_held", bus8.sum, es);
    check("c_out", bus8.c_out, ec);
  endtask

  initial begin
    int dones [$];
    int seen;

    vecs[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[5] = '{8'hA5, 8'h5B, 8'h00, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 8'h00, 1'b1};

    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus1.start = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;

    // Reset for two edges, then release.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_sum", bus8.sum, 0);
    check("rst_cout", bus8.c_out, 0);
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus8.done || bus8.busy) seen++;
      step();
    end
    check("idle_no_activity", seen, 0);

    // Table-driven adds.
    foreach (vecs[i]) do_add(vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_cout, -1);

    // Start while busy is ignored.
    do_add(8'h10, 8'h01, 8'h11, 1'b0, 2);

    // Back-to-back with start held high: done every W+2 cycles.
    bus8.start = 1'b1;
    bus8.a     = 8'h01;
    bus8.b     = 8'h02;
    step();  // first E0
    for (int k = 0; k < 30; k++) begin
      if (bus8.done) begin
        dones.push_back(k);
        check("b2b_sum", bus8.sum, 8'h03);
      end
      if (k == 28) bus8.start = 1'b0;
      if (k < 29) step();
    end
    check("b2b_done_count", dones.size(), 3);
    if (dones.size() == 3) begin
      check("b2b_first", dones[0], W);
      check("b2b_gap1", dones[1] - dones[0], W + 2);
      check("b2b_gap2", dones[2] - dones[1], W + 2);
    end
    step();
    step();

    // Reset on the 4th BUSY edge.
    bus8.start = 1'b1;
    bus8.a     = 8'h80;
    bus8.b     = 8'h80;
    step();  // E0
    bus8.start = 1'b0;
    step();  // E1
    step();  // E2
    step();  // E3
    rst_n = 1'b0;
    step();  // E4 is the reset edge
    rst_n = 1'b1;
    check("midrst_busy", bus8.busy, 0);
    check("midrst_done", bus8.done, 0);
    check("midrst_sum", bus8.sum, 0);
    check("midrst_cout", bus8.c_out, 0);
    seen = 0;
    for (int k = 0; k < W + 4; k++) begin
      if (bus8.done || bus8.busy) seen++;
      step();
    end
    check("midrst_no_done", seen, 0);
    do_add(8'h80, 8'h80, 8'h00, 1'b1, -1);

    // WIDTH=1: one BUSY cycle, then DONE.
    bus1.start = 1'b1;
    bus1.a     = 1'b1;
    bus1.b     = 1'b1;
    step();
    bus1.start = 1'b0;
    bus1.a     = 1'b0;
    bus1.b     = 1'b0;
    check("w1_busy", {bus1.busy, bus1.done}, 2'b10);
    step();
    check("w1_done", {bus1.busy, bus1.done}, 2'b01);
    check("w1_sum", {bus1.c_out, bus1.sum}, 2'b10);
    step();
    check("w1_idle", {bus1.busy, bus1.done}, 2'b00);
    check("w1_hold", {bus1.c_out, bus1.sum}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
